// File: rtl/fma16_stream.sv
// -----------------------------------------------------------------------------
// fma16_stream
//   Registered, flow-controlled wrapper around a combinational half-precision
//   fused multiply-add (fma16). Packets enter an operand stage (S1) that drives
//   the fma16 datapath; the rounded result and flags are captured into an
//   output stage (S2). Sticky IEEE flags and a delivered-result counter are
//   kept for the surrounding unit.
//
// Ports
//   clk, reset              clock, asynchronous active-high reset
//   in_valid / in_ready     input packet handshake
//   in_x, in_y, in_z        half-precision operands
//   in_ctrl                 [5:4] roundmode, [3] mul, [2] add, [1] negp, [0] negz
//   out_valid / out_ready   result handshake
//   out_result, out_flags   result and {invalid, overflow, underflow, inexact}
//   fflags, fflags_clr      sticky flags over delivered results, sync clear
//   done_count              number of delivered results (wraps)
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. A producer holding valid keeps its data stable until the transfer;
// in_ready is a function of pipeline state only and never looks at in_valid.
// -----------------------------------------------------------------------------

// fma16: result = (-1)^negp * x * (mul ? y : 1.0) + (add ? (-1)^negz * z : 0)
// Round modes: 0 RNE, 1 RTZ, 2 RDN, 3 RUP. NaN results are the canonical 7E00.
// Underflow is raised when the exact result is below the smallest normal
// (tininess before rounding) and the result is inexact.
module fma16 (
  input  logic [15:0] x_i,
  input  logic [15:0] y_i,
  input  logic [15:0] z_i,
  input  logic        mul_i,
  input  logic        add_i,
  input  logic        negp_i,
  input  logic        negz_i,
  input  logic [1:0]  rm_i,
  output logic [15:0] result_o,
  output logic [3:0]  flags_o
);
  // Exact sum is held as an integer in units of 2^-48; 82 bits covers the
  // largest product (< 2^80) plus the largest addend.
  localparam int W = 82;
  localparam logic [1:0] RNE = 2'd0;
  localparam logic [1:0] RTZ = 2'd1;
  localparam logic [1:0] RDN = 2'd2;

  logic [15:0] ye, ze;
  assign ye = mul_i ? y_i : 16'h3C00;
  assign ze = add_i ? z_i : 16'h0000;

  logic x_nan, y_nan, z_nan, x_inf, y_inf, z_inf, x_zero, y_zero;
  logic snan_any, nan_any, ps, zs, pz_inv, p_inf, invalid;

  assign x_nan  = (x_i[14:10] == 5'h1F) && (x_i[9:0] != 10'h0);
  assign y_nan  = (ye[14:10]  == 5'h1F) && (ye[9:0]  != 10'h0);
  assign z_nan  = (ze[14:10]  == 5'h1F) && (ze[9:0]  != 10'h0);
  assign x_inf  = (x_i[14:10] == 5'h1F) && (x_i[9:0] == 10'h0);
  assign y_inf  = (ye[14:10]  == 5'h1F) && (ye[9:0]  == 10'h0);
  assign z_inf  = (ze[14:10]  == 5'h1F) && (ze[9:0]  == 10'h0);
  assign x_zero = (x_i[14:0] == 15'h0);
  assign y_zero = (ye[14:0]  == 15'h0);

  assign snan_any = (x_nan & ~x_i[9]) | (y_nan & ~ye[9]) | (z_nan & ~ze[9]);
  assign nan_any  = x_nan | y_nan | z_nan;

  // Without the addend, z acts as a zero of the product's sign so that the
  // product's signed zero passes through unchanged.
  assign ps = x_i[15] ^ ye[15] ^ negp_i;
  assign zs = add_i ? (z_i[15] ^ negz_i) : ps;

  assign pz_inv  = (x_inf & y_zero) | (x_zero & y_inf);
  assign p_inf   = (x_inf | y_inf) & ~x_nan & ~y_nan & ~pz_inv;
  assign invalid = snan_any | pz_inv | (p_inf & z_inf & (ps != zs));

  logic [10:0]  xm, ym, zm, keep;
  logic [4:0]   xe, yex, zex;
  logic [21:0]  prod;
  logic [5:0]   psh;
  logic [W-1:0] p_mag, z_mag, sum;
  logic         rsign, normal, guard, sticky, lost, inc, ovf, to_inf;
  logic [6:0]   ld, sh;
  logic [11:0]  rounded;
  logic [16:0]  base, bits;

  always_comb begin
    xm  = {x_i[14:10] != 5'd0, x_i[9:0]};
    ym  = {ye[14:10]  != 5'd0, ye[9:0]};
    zm  = {ze[14:10]  != 5'd0, ze[9:0]};
    xe  = (x_i[14:10] == 5'd0) ? 5'd1 : x_i[14:10];
    yex = (ye[14:10]  == 5'd0) ? 5'd1 : ye[14:10];
    zex = (ze[14:10]  == 5'd0) ? 5'd1 : ze[14:10];

    // operand value = mant * 2^(exp-25); scale everything by 2^48
    prod  = {11'd0, xm} * {11'd0, ym};
    psh   = {1'b0, xe} + {1'b0, yex} - 6'd2;
    p_mag = {60'd0, prod} << psh;
    z_mag = {71'd0, zm} << ({2'd0, zex} + 7'd23);

    if (ps == zs) begin
      sum   = p_mag + z_mag;
      rsign = ps;
    end else if (p_mag >= z_mag) begin
      sum   = p_mag - z_mag;
      rsign = ps;
    end else begin
      sum   = z_mag - p_mag;
      rsign = zs;
    end
    // exact zero: like-signed zeros keep their sign, anything else is +0
    // except under round-down
    if (sum == '0) rsign = (ps == zs) ? ps : (rm_i == RDN);

    ld = 7'd0;
    for (int i = 0; i < W; i++) begin
      if (sum[i]) ld = 7'(i);
    end

    // bit 34 is 2^-14, the smallest normal; below it the quantum is fixed
    // at the subnormal step 2^-24 (bit 24)
    normal = (ld >= 7'd34);
    sh     = normal ? (ld - 7'd10) : 7'd24;
    keep   = 11'(sum >> sh);
    guard  = sum[sh - 7'd1];
    sticky = |(sum & ~({W{1'b1}} << (sh - 7'd1)));
    lost   = guard | sticky;

    case (rm_i)
      RNE:     inc = guard & (sticky | keep[0]);
      RTZ:     inc = 1'b0;
      RDN:     inc = lost & rsign;
      default: inc = lost & ~rsign;
    endcase

    // The hidden bit in 'rounded' supplies the first exponent step, so a
    // mantissa carry or a subnormal rounding up to 2^-14 falls out of the add.
    rounded = {1'b0, keep} + {11'd0, inc};
    base    = normal ? (({10'd0, ld} - 17'd34) << 10) : 17'd0;
    bits    = base + {5'd0, rounded};
    ovf     = (bits >= 17'h07C00);
    to_inf  = (rm_i == RNE) || ((rm_i == RDN) && rsign) ||
              ((rm_i == 2'd3) && !rsign);
  end

  always_comb begin
    result_o = 16'h0000;
    flags_o  = 4'h0;
    if (nan_any || invalid) begin
      result_o = 16'h7E00;
      flags_o  = {invalid, 3'b000};
    end else if (p_inf) begin
      result_o = {ps, 15'h7C00};
    end else if (z_inf) begin
      result_o = {zs, 15'h7C00};
    end else if (ovf) begin
      result_o = {rsign, to_inf ? 15'h7C00 : 15'h7BFF};
      flags_o  = 4'b0101;
    end else begin
      result_o = {rsign, bits[14:0]};
      flags_o  = {2'b00, ~normal & lost, lost};
    end
  end
endmodule

module fma16_stream #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_x,
  input  logic [15:0]      in_y,
  input  logic [15:0]      in_z,
  input  logic [7:0]       in_ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_result,
  output logic [3:0]       out_flags,
  output logic [3:0]       fflags,
  input  logic             fflags_clr,
  output logic [CNT_W-1:0] done_count
);
  logic             s1_valid_q;
  logic [15:0]      s1_x_q, s1_y_q, s1_z_q;
  logic [5:0]       s1_ctrl_q;
  logic             out_valid_q;
  logic [15:0]      out_result_q;
  logic [3:0]       out_flags_q;
  logic [3:0]       fflags_q, fflags_d;
  logic [CNT_W-1:0] done_count_q;

  logic s1_load, s2_load, delivery;
  logic [15:0] fma_result;
  logic [3:0]  fma_flags;
  logic unused_ctrl;

  assign unused_ctrl = ^in_ctrl[7:6];

  assign s2_load  = s1_valid_q && (!out_valid_q || out_ready);
  assign in_ready = !s1_valid_q || s2_load;
  assign s1_load  = in_valid && in_ready;
  assign delivery = out_valid_q && out_ready;

  fma16 u_fma (
    .x_i      (s1_x_q),
    .y_i      (s1_y_q),
    .z_i      (s1_z_q),
    .mul_i    (s1_ctrl_q[3]),
    .add_i    (s1_ctrl_q[2]),
    .negp_i   (s1_ctrl_q[1]),
    .negz_i   (s1_ctrl_q[0]),
    .rm_i     (s1_ctrl_q[5:4]),
    .result_o (fma_result),
    .flags_o  (fma_flags)
  );

  // clear wins over the old sticky value, the flags being delivered win
  // over the clear
  always_comb begin
    fflags_d = fflags_q;
    if (fflags_clr && delivery) fflags_d = out_flags_q;
    else if (fflags_clr)        fflags_d = 4'h0;
    else if (delivery)          fflags_d = fflags_q | out_flags_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_x_q     <= 16'h0;
      s1_y_q     <= 16'h0;
      s1_z_q     <= 16'h0;
      s1_ctrl_q  <= 6'h0;
    end else if (s1_load) begin
      s1_valid_q <= 1'b1;
      s1_x_q     <= in_x;
      s1_y_q     <= in_y;
      s1_z_q     <= in_z;
      s1_ctrl_q  <= in_ctrl[5:0];
    end else if (s2_load) begin
      s1_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_result_q <= 16'h0;
      out_flags_q  <= 4'h0;
    end else if (s2_load) begin
      out_valid_q  <= 1'b1;
      out_result_q <= fma_result;
      out_flags_q  <= fma_flags;
    end else if (out_ready) begin
      out_valid_q  <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fflags_q     <= 4'h0;
      done_count_q <= '0;
    end else begin
      fflags_q <= fflags_d;
      if (delivery) done_count_q <= done_count_q + 1'b1;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_flags  = out_flags_q;
  assign fflags     = fflags_q;
  assign done_count = done_count_q;
endmodule

// File: tb/tb_fma16_stream.sv
`timescale 1ns/1ps
module tb_fma16_stream;
  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0;
  logic [15:0] in_x = 16'h0, in_y = 16'h0, in_z = 16'h0;
  logic [7:0]  in_ctrl = 8'h0;
  logic        out_ready = 1'b1;
  logic        fflags_clr = 1'b0;

  logic        in_ready, out_valid;
  logic [15:0] out_result;
  logic [3:0]  out_flags, fflags;
  logic [31:0] done_count;
  logic        in_ready4, out_valid4;
  logic [15:0] out_result4;
  logic [3:0]  out_flags4, fflags4;
  logic [3:0]  done_count4;

  fma16_stream #(.CNT_W(32)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_z(in_z), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_flags(out_flags), .fflags(fflags), .fflags_clr(fflags_clr),
    .done_count(done_count)
  );

  // narrow-counter copy fed with identical stimulus, for wrap-around
  fma16_stream #(.CNT_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready4),
    .in_x(in_x), .in_y(in_y), .in_z(in_z), .in_ctrl(in_ctrl),
    .out_valid(out_valid4), .out_ready(out_ready), .out_result(out_result4),
    .out_flags(out_flags4), .fflags(fflags4), .fflags_clr(fflags_clr),
    .done_count(done_count4)
  );

  // ---------------- bookkeeping ----------------
  int total = 0;
  int bad = 0;
  logic [19:0] exp_q[$];          // {flags, result} in acceptance order
  logic [3:0]  m_fflags = 4'h0;
  logic [31:0] m_count = 32'h0;
  logic        pend_dlv = 1'b0, pend_clr = 1'b0;
  logic [3:0]  pend_flags = 4'h0;
  logic        hold_v = 1'b0;
  logic [19:0] hold_val = 20'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic is_nan(input logic [15:0] h);
    return (h[14:10] == 5'h1F) && (h[9:0] != 0);
  endfunction
  function automatic logic is_inf(input logic [15:0] h);
    return (h[14:10] == 5'h1F) && (h[9:0] == 0);
  endfunction
  // magnitude of a finite half in units of 2^-24
  function automatic logic [127:0] mag24(input logic [15:0] h);
    logic [127:0] m;
    if (h[14:10] == 0) m = {118'd0, h[9:0]};
    else m = {117'd0, 1'b1, h[9:0]} << (h[14:10] - 1);
    return m;
  endfunction
  function automatic int msb(input logic [127:0] v);
    int p = -1;
    for (int i = 0; i < 128; i++) if (v[i]) p = i;
    return p;
  endfunction

  function automatic logic [19:0] fma_ref(input logic [15:0] x, input logic [15:0] yi,
                                          input logic [15:0] zi, input logic [7:0] c);
    logic [1:0] rm;
    logic [15:0] y, z;
    logic sp, sc, neg, inexact, tiny, ovf, nan_in, snan_in, inv;
    logic [127:0] pm, cm, mag, q, n, r, rr;
    logic signed [131:0] sv;
    logic [15:0] res;
    int e;
    rm = c[5:4];
    y  = c[3] ? yi : 16'h3C00;
    z  = zi;
    sp = x[15] ^ y[15] ^ c[1];
    sc = z[15] ^ c[0];
    nan_in  = is_nan(x) || is_nan(y) || (c[2] && is_nan(z));
    snan_in = (is_nan(x) && !x[9]) || (is_nan(y) && !y[9]) || (c[2] && is_nan(z) && !z[9]);
    inv = snan_in
       || (is_inf(x) && y[14:0] == 0) || (x[14:0] == 0 && is_inf(y))
       || (!nan_in && (is_inf(x) || is_inf(y)) && c[2] && is_inf(z) && sp != sc);
    if (nan_in || inv) return {inv, 3'b000, 16'h7E00};
    if (is_inf(x) || is_inf(y)) return {4'h0, sp, 15'h7C00};
    if (c[2] && is_inf(z)) return {4'h0, sc, 15'h7C00};
    pm = mag24(x) * mag24(y);
    cm = c[2] ? (mag24(z) << 24) : 128'd0;
    if (!c[2]) sc = sp;
    sv = (sp ? -$signed({4'd0, pm}) : $signed({4'd0, pm})) +
         (sc ? -$signed({4'd0, cm}) : $signed({4'd0, cm}));
    neg = (sv < 0);
    mag = neg ? 128'(-sv) : 128'(sv);
    if (mag == 0) neg = (sp == sc) ? sp : (rm == 2'd2);
    tiny = (mag != 0) && (mag < (128'd1 << 34));
    q = tiny || mag == 0 ? (128'd1 << 24) : (128'd1 << (msb(mag) - 10));
    n = mag / q;
    r = mag % q;
    inexact = (r != 0);
    case (rm)
      2'd0: if (2 * r > q || (2 * r == q && n[0])) n = n + 1;
      2'd2: if (inexact && neg) n = n + 1;
      2'd3: if (inexact && !neg) n = n + 1;
      default: ;
    endcase
    rr  = n * q;
    ovf = (rr >= (128'd1 << 64));
    if (ovf) begin
      if (rm == 2'd0 || (rm == 2'd2 && neg) || (rm == 2'd3 && !neg)) res = {neg, 15'h7C00};
      else res = {neg, 15'h7BFF};
      return {4'b0101, res};
    end
    if (rr < (128'd1 << 34)) begin
      res = {neg, 5'd0, 10'(rr >> 24)};
    end else begin
      e   = msb(rr);
      res = {neg, 5'(e - 33), 10'((rr >> (e - 10)) - 1024)};
    end
    return {1'b0, 1'b0, tiny && inexact, inexact, res};
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!reset) begin
      check("fflags", {28'd0, fflags}, {28'd0, m_fflags});
      check("done_count", done_count, m_count);
      check("done_count4", {28'd0, done_count4}, {28'd0, m_count[3:0]});
      if (hold_v && out_valid) check("stall_hold", {12'd0, out_flags, out_result}, {12'd0, hold_val});
      hold_v   = out_valid && !out_ready;
      hold_val = {out_flags, out_result};
      pend_dlv = 1'b0;
      pend_clr = fflags_clr;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_result: got %h with no expected entry", out_result);
        end else begin
          logic [19:0] e;
          e = exp_q.pop_front();
          check("result", {16'd0, out_result}, {16'd0, e[15:0]});
          check("flags", {28'd0, out_flags}, {28'd0, e[19:16]});
          pend_dlv   = 1'b1;
          pend_flags = e[19:16];
        end
      end
    end
  end

  always @(posedge clk) begin
    if (!reset) begin
      if (pend_dlv && pend_clr) m_fflags = pend_flags;
      else if (pend_clr)        m_fflags = 4'h0;
      else if (pend_dlv)        m_fflags = m_fflags | pend_flags;
      if (pend_dlv) m_count = m_count + 1;
      pend_dlv = 1'b0;
      pend_clr = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  // called at posedge+1; returns at posedge+1 after the accepting edge
  task automatic send(input logic [15:0] x, input logic [15:0] y,
                      input logic [15:0] z, input logic [7:0] c);
    int n = 0;
    in_valid = 1'b1; in_x = x; in_y = y; in_z = z; in_ctrl = c;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", n);
    end else begin
      exp_q.push_back(fma_ref(x, y, z, c));
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || out_valid) && n < 500) begin
      n++;
      @(negedge clk);
    end
    if (exp_q.size() != 0 || out_valid) begin
      total++; bad++;
      $display("FAIL drain_timeout: %0d results outstanding", exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [15:0] specials [12] = '{16'h0000, 16'h8000, 16'h7C00, 16'hFC00, 16'h7E00, 16'h7D00,
                                 16'h0001, 16'h03FF, 16'h0400, 16'h7BFF, 16'h3C00, 16'hBC00};
  function automatic logic [15:0] rand_half();
    if ($urandom_range(0, 4) == 0) return specials[$urandom_range(0, 11)];
    return {1'($urandom_range(0, 1)), 5'($urandom_range(0, 30)), 10'($urandom_range(0, 1023))};
  endfunction

  // ---------------- main sequence ----------------
  logic stop = 1'b0;
  logic seen_full = 1'b0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #22 reset = 1'b0;
    @(posedge clk); #1;
    // reset state
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_result", {16'd0, out_result}, 32'd0);
    check("rst_flags", {28'd0, out_flags}, 32'd0);

    // single packet latency and value
    send(16'h3C00, 16'h4000, 16'h3C00, 8'h0C);
    @(negedge clk);
    check("lat_edge_t", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check("lat_edge_t1", {31'd0, out_valid}, 32'd1);
    check("first_result", {16'd0, out_result}, 32'h4200);
    drain();
    check("first_count", done_count, 32'd1);

    // overflow then invalid, sticky accumulation
    send(16'h7BFF, 16'h7BFF, 16'h0000, 8'h0C);
    drain();
    check("fflags_ovf", {28'd0, fflags}, 32'h5);
    send(16'h7C00, 16'h0000, 16'h0000, 8'h0C);
    drain();
    check("fflags_inv", {28'd0, fflags}, 32'hD);

    // 8-packet stream with a 5-cycle stall
    fork
      begin
        for (int i = 0; i < 8; i++) send(rand_half(), rand_half(), rand_half(), 8'($urandom));
      end
      begin
        tick(3);
        out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          if (!in_ready) seen_full = 1'b1;
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    check("in_ready_drop", {31'd0, seen_full}, 32'd1);
    drain();
    check("stream_count", done_count, 32'd11);

    // sticky clear alone, then clear coinciding with a delivery
    fflags_clr = 1'b1; tick(1); fflags_clr = 1'b0;
    @(negedge clk);
    check("clr_alone", {28'd0, fflags}, 32'd0);
    tick(1);
    send(16'h7C00, 16'h0000, 16'h3C00, 8'h0C);
    drain();
    check("fflags_inv2", {28'd0, fflags}, 32'h8);
    out_ready = 1'b0;
    send(16'h7BFF, 16'h7BFF, 16'h0000, 8'h0C);
    tick(1);
    fflags_clr = 1'b1; out_ready = 1'b1;
    tick(1);
    fflags_clr = 1'b0;
    @(negedge clk);
    check("clr_with_dlv", {28'd0, fflags}, 32'h5);
    tick(1);

    // randomized traffic with random backpressure and clears
    stop = 1'b0;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          send(rand_half(), rand_half(), rand_half(), 8'($urandom));
          if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 3));
        end
        stop = 1'b1;
      end
      begin
        while (!stop) begin
          @(posedge clk); #1;
          out_ready  = ($urandom_range(0, 3) != 0);
          fflags_clr = ($urandom_range(0, 9) == 0);
        end
        out_ready = 1'b1; fflags_clr = 1'b0;
      end
    join
    drain();

    // reset with both stages full
    send(16'h7BFF, 16'h7BFF, 16'h0000, 8'h0C);
    drain();
    out_ready = 1'b0;
    send(rand_half(), rand_half(), rand_half(), 8'h0C);
    send(rand_half(), rand_half(), rand_half(), 8'h0C);
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    #1 reset = 1'b1;
    exp_q.delete();
    m_fflags = 4'h0; m_count = 32'h0; pend_dlv = 1'b0; pend_clr = 1'b0; hold_v = 1'b0;
    #1;
    check("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_mid_fflags", {28'd0, fflags}, 32'd0);
    check("rst_mid_count", done_count, 32'd0);
    check("rst_mid_count4", {28'd0, done_count4}, 32'd0);
    tick(2);
    #1 reset = 1'b0;
    out_ready = 1'b1;
    tick(5);
    check("no_stale", {31'd0, out_valid}, 32'd0);

    // counter wrap on the 4-bit instance
    for (int i = 0; i < 17; i++) send(rand_half(), rand_half(), rand_half(), 8'($urandom));
    drain();
    check("wrap_count4", {28'd0, done_count4}, 32'd1);
    check("wrap_count32", done_count, 32'd17);

    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
